// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and pointer synchronisers.
// Conversions work on a wide vector; callers zero-extend and truncate.
package gray_pkg;

    localparam int MAXW = 64;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary_n.sv
// Prefix-XOR Gray to binary conversion, N bits wide.
// Each bit is the XOR of all Gray bits at or above it.
module gray_to_binary_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray counter with binary or Gray load.
// Binary and Gray values are both registered so gray_out is glitch-free.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] RST_GRAY =
        WIDTH'(bin2gray(MAXW'(RESET_VAL)));

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_nxt_gray;
    logic             w_wrap_nxt;
    logic             w_cnt_up;
    logic             w_cnt_dn;

    gray_to_binary_n #(
        .WIDTH(WIDTH)
    ) u_g2b (
        .i_gray(load_val),
        .o_bin (w_load_bin)
    );

    assign w_cnt_up = !load && en && (up_dn == DIR_UP);
    assign w_cnt_dn = !load && en && (up_dn == DIR_DN);

    always_comb begin
        w_nxt      = r_bin;
        w_wrap_nxt = 1'b0;
        unique case (1'b1)
            load: begin
                w_nxt = load_is_gray ? w_load_bin : load_val;
            end
            w_cnt_up: begin
                if (r_bin != MAXV) begin
                    w_nxt = r_bin + 1'b1;
                end else if (!SATURATE) begin
                    w_nxt      = '0;
                    w_wrap_nxt = 1'b1;
                end
            end
            w_cnt_dn: begin
                if (r_bin != '0) begin
                    w_nxt = r_bin - 1'b1;
                end else if (!SATURATE) begin
                    w_nxt      = MAXV;
                    w_wrap_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gray is computed from the next binary value so both regs update together.
    assign w_nxt_gray = WIDTH'(bin2gray(MAXW'(w_nxt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= RESET_VAL;
            r_gray <= RST_GRAY;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_nxt;
            r_gray <= w_nxt_gray;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;
    assign at_limit = (up_dn == DIR_UP) ? (r_bin == MAXV) : (r_bin == '0);

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: wrap, saturate and 8-bit reset-value instances.
// A reference model pushes expected outputs that are popped after each edge.
module tb_gray_counter_n;

    typedef struct {
        int         k;
        logic [7:0] bin;
        logic [7:0] gray;
        logic       wrap;
        logic       lim;
    } exp_t;

    exp_t sbq[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic       load_is_gray = 1'b0;
    logic [7:0] lv = 8'h00;

    logic [3:0] bin_a, gray_a, bin_s, gray_s;
    logic [7:0] bin_8, gray_8;
    logic       wrap_a, lim_a, wrap_s, lim_s, wrap_8, lim_8;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb[3];
    logic       mw[3];
    int         wd[3] = '{4, 4, 8};
    bit         sat[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] rv[3] = '{8'h00, 8'h00, 8'h20};

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_is_gray(load_is_gray), .load_val(lv[3:0]),
        .bin_out(bin_a), .gray_out(gray_a), .wrap(wrap_a), .at_limit(lim_a)
    );

    gray_counter_n #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'h0)) u_s (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_is_gray(load_is_gray), .load_val(lv[3:0]),
        .bin_out(bin_s), .gray_out(gray_s), .wrap(wrap_s), .at_limit(lim_s)
    );

    gray_counter_n #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'h20)) u_8 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_is_gray(load_is_gray), .load_val(lv),
        .bin_out(bin_8), .gray_out(gray_8), .wrap(wrap_8), .at_limit(lim_8)
    );

    function automatic logic [7:0] b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        logic       acc;
        acc = 1'b0;
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic logic [7:0] mask_of(input int k);
        return (wd[k] == 8) ? 8'hFF : 8'h0F;
    endfunction

    function automatic exp_t expect_of(input int k);
        exp_t e;
        e.k    = k;
        e.bin  = mb[k];
        e.gray = b2g(mb[k]);
        e.wrap = mw[k];
        e.lim  = up_dn ? (mb[k] == mask_of(k)) : (mb[k] == 8'h00);
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mb[k] = rv[k];
            mw[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [7:0] m;
        for (int k = 0; k < 3; k++) begin
            m = mask_of(k);
            mw[k] = 1'b0;
            if (load) begin
                mb[k] = load_is_gray ? g2b(lv & m) : (lv & m);
            end else if (en && up_dn) begin
                if (mb[k] == m) begin
                    if (!sat[k]) begin
                        mb[k] = 8'h00;
                        mw[k] = 1'b1;
                    end
                end else begin
                    mb[k] = mb[k] + 8'h01;
                end
            end else if (en) begin
                if (mb[k] == 8'h00) begin
                    if (!sat[k]) begin
                        mb[k] = m;
                        mw[k] = 1'b1;
                    end
                end else begin
                    mb[k] = mb[k] - 8'h01;
                end
            end
        end
    endtask

    task automatic push_all();
        for (int k = 0; k < 3; k++) sbq.push_back(expect_of(k));
    endtask

    task automatic get_act(input int k, output logic [7:0] b,
                           output logic [7:0] g, output logic w,
                           output logic l);
        if (k == 0) begin
            b = {4'h0, bin_a}; g = {4'h0, gray_a}; w = wrap_a; l = lim_a;
        end else if (k == 1) begin
            b = {4'h0, bin_s}; g = {4'h0, gray_s}; w = wrap_s; l = lim_s;
        end else begin
            b = bin_8; g = gray_8; w = wrap_8; l = lim_8;
        end
    endtask

    task automatic compare_pop(input string tag);
        exp_t       e;
        logic [7:0] b, g;
        logic       w, l;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            get_act(e.k, b, g, w, l);
            checks++;
            if (b !== e.bin) begin
                errors++;
                $display("FAIL %s inst%0d bin got %h want %h", tag, e.k, b, e.bin);
            end
            checks++;
            if (g !== e.gray) begin
                errors++;
                $display("FAIL %s inst%0d gray got %h want %h", tag, e.k, g, e.gray);
            end
            checks++;
            if (w !== e.wrap) begin
                errors++;
                $display("FAIL %s inst%0d wrap got %b want %b", tag, e.k, w, e.wrap);
            end
            checks++;
            if (l !== e.lim) begin
                errors++;
                $display("FAIL %s inst%0d at_limit got %b want %b", tag, e.k, l, e.lim);
            end
        end
    endtask

    task automatic step(input string tag, input logic i_en, input logic i_up,
                        input logic i_ld, input logic i_isg,
                        input logic [7:0] i_lv);
        logic [3:0] prev;
        en = i_en; up_dn = i_up; load = i_ld; load_is_gray = i_isg; lv = i_lv;
        prev = gray_a;
        model_step();
        push_all();
        @(posedge clk);
        #1;
        if (i_en && !i_ld) begin
            checks++;
            if ($countones(prev ^ gray_a) != 1) begin
                errors++;
                $display("FAIL %s gray_step got %b->%b want 1-bit change",
                         tag, prev, gray_a);
            end
        end
        compare_pop(tag);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        push_all();
        #1;
        compare_pop("reset");
        #2 rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        for (int i = 0; i < 5; i++) step("count_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_a !== 4'd5 || gray_a !== 4'b0111) begin
            errors++;
            $display("FAIL count_up5 got %h/%b want 5/0111", bin_a, gray_a);
        end
    endtask

    task automatic test_wrap_up();
        for (int i = 0; i < 10; i++) step("to_max", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (gray_a !== 4'b1000) begin
            errors++;
            $display("FAIL max_gray got %b want 1000", gray_a);
        end
        step("wrap_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (wrap_a !== 1'b1 || bin_a !== 4'd0) begin
            errors++;
            $display("FAIL wrap_up_pulse got %b/%h want 1/0", wrap_a, bin_a);
        end
        step("wrap_clear", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_wrap_down();
        step("wrap_dn", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_a !== 4'd15 || gray_a !== 4'b1000 || wrap_a !== 1'b1) begin
            errors++;
            $display("FAIL wrap_dn got %h/%b/%b want f/1000/1", bin_a, gray_a, wrap_a);
        end
        step("dn_14", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_a !== 4'd14 || gray_a !== 4'b1001) begin
            errors++;
            $display("FAIL dn_14 got %h/%b want e/1001", bin_a, gray_a);
        end
    endtask

    task automatic test_load();
        step("load_gray", 1'b1, 1'b1, 1'b1, 1'b1, 8'h0D);
        checks++;
        if (bin_a !== 4'd9 || gray_a !== 4'b1101) begin
            errors++;
            $display("FAIL load_gray got %h/%b want 9/1101", bin_a, gray_a);
        end
        step("load_bin", 1'b1, 1'b0, 1'b1, 1'b0, 8'h09);
    endtask

    task automatic test_saturate();
        step("sat_load", 1'b0, 1'b1, 1'b1, 1'b0, 8'h0E);
        for (int i = 0; i < 3; i++) step("sat_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_s !== 4'd15 || lim_s !== 1'b1 || wrap_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold got %h/%b/%b want f/1/0", bin_s, lim_s, wrap_s);
        end
        step("sat_dn", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_s !== 4'd14) begin
            errors++;
            $display("FAIL sat_dn got %h want e", bin_s);
        end
    endtask

    task automatic test_async_reset();
        step("ld_50", 1'b0, 1'b1, 1'b1, 1'b0, 8'h50);
        for (int i = 0; i < 7; i++) step("to_57", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_8 !== 8'h57) begin
            errors++;
            $display("FAIL reach_57 got %h want 57", bin_8);
        end
        #2 rst_n = 1'b0;
        model_reset();
        push_all();
        #1;
        checks++;
        if (bin_8 !== 8'h20 || gray_8 !== 8'h30) begin
            errors++;
            $display("FAIL async_rst got %h/%h want 20/30", bin_8, gray_8);
        end
        compare_pop("async_rst");
        #2 rst_n = 1'b1;
        step("resume", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++;
        if (bin_8 !== 8'h21) begin
            errors++;
            $display("FAIL resume got %h want 21", bin_8);
        end
        step("resume2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        step("b2b_ld0", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step("b2b_dn", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("b2b_up", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step("b2b_dn2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("b2b_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_saturate();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
